// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, wrap/saturate bounds, terminal-count pulse and sticky overflow.
// One count update per cycle; outputs registered, no backpressure (en gates progress).
module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  sat,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      max_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr_ovf,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  ovf
);

  logic [PRESCALE_W-1:0] pcnt;
  logic                  tick;
  logic [WIDTH-1:0]      step_val;
  logic                  step_bound;
  logic [WIDTH-1:0]      load_clamped;

  // >= rather than == so a prescale lowered mid-period ticks on the next enabled cycle.
  assign tick         = en && (pcnt >= prescale);
  assign load_clamped = (load_val > max_val) ? max_val : load_val;

  always_comb begin
    step_val   = count;
    step_bound = 1'b0;
    if (up) begin
      if (count < max_val) begin
        step_val = count + WIDTH'(1);
      end else begin
        step_val   = sat ? max_val : '0;
        step_bound = 1'b1;
      end
    end else if (count > max_val) begin
      // max_val was lowered below the current count: pull in without flagging.
      step_val = max_val;
    end else if (count != '0) begin
      step_val = count - WIDTH'(1);
    end else begin
      step_val   = sat ? '0 : max_val;
      step_bound = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt  <= '0;
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      pcnt  <= '0;
      count <= load_clamped;
      tc    <= 1'b0;
      if (clr_ovf) ovf <= 1'b0;
    end else begin
      if (en) pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);
      if (tick) count <= step_val;
      tc <= tick && step_bound;
      if (tick && step_bound) ovf <= 1'b1;
      else if (clr_ovf)       ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Directed-vector bench for prog_counter; expectations queued by stimulus, checked by a monitor.
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, sat, load, clr_ovf;
  logic [7:0] load_val, max_val;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       tc, ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    c;
    int    t;
    int    o;
    string nm;
  } exp_t;

  exp_t sb[$];

  prog_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .max_val(max_val), .prescale(prescale),
    .clr_ovf(clr_ovf), .count(count), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Monitor: after every rising edge, pop the expectation queued for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (32'(count) !== e.c) begin
          errors++;
          $display("FAIL %s count: got %0d want %0d", e.nm, count, e.c);
        end
        checks++;
        if (32'(tc) !== e.t) begin
          errors++;
          $display("FAIL %s tc: got %0b want %0d", e.nm, tc, e.t);
        end
        checks++;
        if (32'(ovf) !== e.o) begin
          errors++;
          $display("FAIL %s ovf: got %0b want %0d", e.nm, ovf, e.o);
        end
      end
    end
  end

  // Called at a falling edge with inputs already set; queues the result of the next rising edge.
  task automatic chk(input int c, input int t, input int o, input string nm);
    exp_t e;
    e.c  = c;
    e.t  = t;
    e.o  = o;
    e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    load_val = 8'd0; max_val = 8'd255; prescale = 4'd0;
    @(negedge clk);

    // Reset, then idle with en low.
    for (int i = 0; i < 2; i++) chk(0, 0, 0, "reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) chk(0, 0, 0, "idle");

    // Full 8-bit wrap.
    en = 1'b1;
    for (int i = 1; i <= 256; i++)
      chk(i % 256, (i == 256) ? 1 : 0, (i == 256) ? 1 : 0, "wrap256");
    en = 1'b0;
    chk(0, 0, 1, "wrap_hold");
    clr_ovf = 1'b1;
    chk(0, 0, 0, "clr_ovf");
    clr_ovf = 1'b0;

    // Saturate up at max_val=9.
    max_val = 8'd9; sat = 1'b1; up = 1'b1;
    load = 1'b1; load_val = 8'd7;
    chk(7, 0, 0, "sat_load");
    load = 1'b0; en = 1'b1;
    chk(8, 0, 0, "sat_8");
    chk(9, 0, 0, "sat_9");
    for (int i = 0; i < 3; i++) chk(9, 1, 1, "sat_hold");
    clr_ovf = 1'b1;
    chk(9, 1, 1, "clr_vs_event");
    en = 1'b0;
    chk(9, 0, 0, "clr_after_sat");
    clr_ovf = 1'b0;

    // Wrap down at max_val=9, clamped load, lowered max_val.
    sat = 1'b0; up = 1'b0;
    load = 1'b1; load_val = 8'd2;
    chk(2, 0, 0, "dn_load");
    load = 1'b0; en = 1'b1;
    chk(1, 0, 0, "dn_1");
    chk(0, 0, 0, "dn_0");
    chk(9, 1, 1, "dn_wrap");
    chk(8, 0, 1, "dn_8");
    en = 1'b0; load = 1'b1; load_val = 8'd200;
    chk(9, 0, 1, "load_clamp");
    load = 1'b0; en = 1'b1; max_val = 8'd5;
    chk(5, 0, 1, "max_lowered");
    chk(4, 0, 1, "dn_4");
    en = 1'b0; clr_ovf = 1'b1;
    chk(4, 0, 0, "clr2");
    clr_ovf = 1'b0;

    // Prescaler: step every 4th enabled cycle, en gaps stretch the period.
    max_val = 8'd255; up = 1'b1; prescale = 4'd3;
    load = 1'b1; load_val = 8'd0;
    chk(0, 0, 0, "ps_load");
    load = 1'b0; en = 1'b1;
    chk(0, 0, 0, "ps_p1");
    chk(0, 0, 0, "ps_p2");
    chk(0, 0, 0, "ps_p3");
    chk(1, 0, 0, "ps_tick1");
    chk(1, 0, 0, "ps_q1");
    chk(1, 0, 0, "ps_q2");
    en = 1'b0;
    chk(1, 0, 0, "ps_gap1");
    chk(1, 0, 0, "ps_gap2");
    en = 1'b1;
    chk(1, 0, 0, "ps_q3");
    chk(2, 0, 0, "ps_tick2");
    chk(2, 0, 0, "ps_r1");
    chk(2, 0, 0, "ps_r2");
    prescale = 4'd1;
    chk(3, 0, 0, "ps_lowered");
    prescale = 4'd0;
    chk(4, 0, 0, "ps0_a");
    chk(5, 0, 0, "ps0_b");

    // Load beats a tick at the bound; reset mid-count and mid-period.
    max_val = 8'd9; en = 1'b0; load = 1'b1; load_val = 8'd9;
    chk(9, 0, 0, "ld_bound");
    en = 1'b1; load_val = 8'd3;
    chk(3, 0, 0, "ld_vs_tick");
    load = 1'b0;
    chk(4, 0, 0, "post_ld4");
    chk(5, 0, 0, "post_ld5");
    rst = 1'b1;
    chk(0, 0, 0, "rst_at5");
    rst = 1'b0;
    chk(1, 0, 0, "rst_resume");
    prescale = 4'd2;
    chk(1, 0, 0, "rp_1");
    chk(1, 0, 0, "rp_2");
    chk(2, 0, 0, "rp_tick");
    chk(2, 0, 0, "rp_mid");
    rst = 1'b1;
    chk(0, 0, 0, "rst_midperiod");
    rst = 1'b0;
    chk(0, 0, 0, "rp_full1");
    chk(0, 0, 0, "rp_full2");
    chk(1, 0, 0, "rp_full_tick");
    en = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
